// File: rtl/axis_ddr3_writer_if.sv
// Stream input plus AXI4 write-channel bundle for the capture-path writer.
// master is the writer's view; slave is the view of whatever sits on the other side.
interface axis_ddr3_writer_if;
    logic        s_tvalid;
    logic        s_tready;
    logic [31:0] s_tdata;

    logic        awvalid;
    logic        awready;
    logic [31:0] awaddr;
    logic [3:0]  awid;
    logic [7:0]  awlen;
    logic [1:0]  awburst;

    logic        wvalid;
    logic        wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;

    logic        bvalid;
    logic        bready;
    logic [1:0]  bresp;
    logic [3:0]  bid;

    modport master (
        input  s_tvalid, s_tdata,
        output s_tready,
        output awvalid, awaddr, awid, awlen, awburst,
        input  awready,
        output wvalid, wdata, wstrb, wlast,
        input  wready,
        input  bvalid, bresp, bid,
        output bready
    );

    modport slave (
        output s_tvalid, s_tdata,
        input  s_tready,
        input  awvalid, awaddr, awid, awlen, awburst,
        output awready,
        input  wvalid, wdata, wstrb, wlast,
        output wready,
        output bvalid, bresp, bid,
        input  bready
    );
endinterface

// File: rtl/axis_ddr3_writer.sv
// Buffers a 32-bit sample stream and writes it as fixed-length AXI4 INCR bursts
// into a circular DDR3 region, one burst outstanding at a time.
module axis_ddr3_writer #(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int          BUF_BYTES  = 65536,
    parameter int          BURST_LEN  = 16,
    parameter int          FIFO_DEPTH = 32,
    parameter logic [3:0]  AXI_ID     = 4'h0
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       enable_i,
    axis_ddr3_writer_if.master         bus,
    output logic [31:0]                wr_ptr_o,
    output logic                       wrap_o,
    output logic                       err_o,
    output logic                       busy_o
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BEAT_W = $clog2(BURST_LEN);

    localparam logic [31:0]       BURST_BYTES = 32'(BURST_LEN * 4);
    localparam logic [31:0]       BUF_MASK    = 32'(BUF_BYTES - 1);
    localparam logic [CNT_W-1:0]  DEPTH_CNT   = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]  BURST_CNT   = CNT_W'(BURST_LEN);
    localparam logic [BEAT_W-1:0] LAST_BEAT   = BEAT_W'(BURST_LEN - 1);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

    // ---------------- stream FIFO ----------------
    logic [31:0]      mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_idx_reg;
    logic [PTR_W-1:0] rd_idx_reg;
    logic [PTR_W-1:0] rd_idx_next;
    logic [CNT_W-1:0] count_reg;
    logic [31:0]      head_reg;
    logic             push;
    logic             pop;

    logic             aw_valid;
    logic             w_valid;
    logic             b_ready;

    assign bus.s_tready = (count_reg < DEPTH_CNT);
    assign push         = bus.s_tvalid & bus.s_tready;
    assign pop          = w_valid & bus.wready;
    assign rd_idx_next  = pop ? rd_idx_reg + PTR_W'(1) : rd_idx_reg;

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_idx_reg] <= bus.s_tdata;
        end
    end

    // Registered read of the next head; a word written into the slot that becomes
    // the head on this same edge is forwarded so the head is never stale.
    always_ff @(posedge clock) begin
        if (push && (wr_idx_reg == rd_idx_next)) begin
            head_reg <= bus.s_tdata;
        end else begin
            head_reg <= mem[rd_idx_next];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_idx_reg <= '0;
            rd_idx_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_idx_reg <= wr_idx_reg + PTR_W'(1);
            end
            rd_idx_reg <= rd_idx_next;
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // ---------------- burst FSM ----------------
    state_t            state_reg;
    state_t            state_next;
    logic [BEAT_W-1:0] beat_reg;
    logic [BEAT_W-1:0] beat_next;
    logic [31:0]       wr_ptr_reg;
    logic [31:0]       wr_ptr_next;
    logic [31:0]       wr_ptr_adv;
    logic              wrap_reg;
    logic              wrap_next;
    logic              err_reg;
    logic              err_next;

    assign wr_ptr_adv = (wr_ptr_reg + BURST_BYTES) & BUF_MASK;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg  <= IDLE;
            beat_reg   <= '0;
            wr_ptr_reg <= '0;
            wrap_reg   <= 1'b0;
            err_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            beat_reg   <= beat_next;
            wr_ptr_reg <= wr_ptr_next;
            wrap_reg   <= wrap_next;
            err_reg    <= err_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        beat_next   = beat_reg;
        wr_ptr_next = wr_ptr_reg;
        wrap_next   = 1'b0;
        err_next    = err_reg;
        aw_valid    = 1'b0;
        w_valid     = 1'b0;
        b_ready     = 1'b0;
        case (state_reg)
            IDLE: begin
                // A burst only starts once the whole burst is buffered, so W never stalls on data.
                if (enable_i && (count_reg >= BURST_CNT)) begin
                    state_next = ADDR;
                end
            end
            ADDR: begin
                aw_valid = 1'b1;
                if (bus.awready) begin
                    state_next = DATA;
                    beat_next  = '0;
                end
            end
            DATA: begin
                w_valid = 1'b1;
                if (bus.wready) begin
                    if (beat_reg == LAST_BEAT) begin
                        state_next = RESP;
                        beat_next  = '0;
                    end else begin
                        beat_next = beat_reg + BEAT_W'(1);
                    end
                end
            end
            RESP: begin
                b_ready = 1'b1;
                if (bus.bvalid) begin
                    if (bus.bresp != 2'b00) begin
                        err_next = 1'b1;
                    end
                    wr_ptr_next = wr_ptr_adv;
                    wrap_next   = (wr_ptr_adv == 32'd0);
                    state_next  = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ---------------- outputs ----------------
    assign bus.awvalid = aw_valid;
    assign bus.awaddr  = BASE_ADDR + wr_ptr_reg;
    assign bus.awid    = AXI_ID;
    assign bus.awlen   = 8'(BURST_LEN - 1);
    assign bus.awburst = 2'b01;
    assign bus.wvalid  = w_valid;
    assign bus.wdata   = head_reg;
    assign bus.wstrb   = 4'hF;
    assign bus.wlast   = w_valid & (beat_reg == LAST_BEAT);
    assign bus.bready  = b_ready;

    assign wr_ptr_o = wr_ptr_reg;
    assign wrap_o   = wrap_reg;
    assign err_o    = err_reg;
    assign busy_o   = (state_reg != IDLE);

    // Response ID carries no information with a single outstanding burst.
    logic unused_bid;
    assign unused_bid = ^bus.bid;

endmodule

// File: tb/tb_axis_ddr3_writer.sv
// Directed bench for axis_ddr3_writer: 128-byte ring at 0x1_0000, 16-beat bursts.
module tb_axis_ddr3_writer;

    localparam logic [31:0] BASE = 32'h0001_0000;

    logic        clk;
    logic        reset;
    logic        enable;
    logic [31:0] wr_ptr;
    logic        wrap;
    logic        err;
    logic        busy;

    int tests_run    = 0;
    int tests_failed = 0;

    axis_ddr3_writer_if bus();

    axis_ddr3_writer #(
        .BASE_ADDR (BASE),
        .BUF_BYTES (128),
        .BURST_LEN (16),
        .FIFO_DEPTH(32),
        .AXI_ID    (4'h5)
    ) dut (
        .clock   (clk),
        .reset   (reset),
        .enable_i(enable),
        .bus     (bus),
        .wr_ptr_o(wr_ptr),
        .wrap_o  (wrap),
        .err_o   (err),
        .busy_o  (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // B responder: answers one cycle after bready rises.
    initial begin
        bus.bvalid = 1'b0;
        forever begin
            @(negedge clk);
            bus.bvalid = bus.bready;
        end
    end

    // Bus monitor: samples 1 ns before each rising edge.
    logic [31:0] aw_q[$];
    logic [31:0] w_q[$];
    logic        wl_q[$];
    int b_n, wrap_n, wrap_at_b, awv_n, aw_field_err, wstrb_err, w_order_err;

    initial begin
        forever begin
            @(negedge clk);
            #4;
            if (reset) begin
                aw_q.delete();
                w_q.delete();
                wl_q.delete();
                b_n = 0; wrap_n = 0; wrap_at_b = 0; awv_n = 0;
                aw_field_err = 0; wstrb_err = 0; w_order_err = 0;
            end else begin
                if (bus.awvalid) awv_n++;
                if (bus.awvalid && bus.awready) begin
                    aw_q.push_back(bus.awaddr);
                    if (bus.awlen != 8'd15 || bus.awid != 4'h5 || bus.awburst != 2'b01)
                        aw_field_err++;
                end
                if (bus.wvalid && bus.wready) begin
                    if (aw_q.size() <= b_n) w_order_err++;
                    if (bus.wstrb != 4'hF) wstrb_err++;
                    w_q.push_back(bus.wdata);
                    wl_q.push_back(bus.wlast);
                end
                if (bus.bvalid && bus.bready) b_n++;
                if (wrap) begin
                    wrap_n++;
                    wrap_at_b = b_n;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    task automatic do_reset();
        step();
        reset = 1'b1;
        bus.s_tvalid = 1'b0;
        step();
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic push_words(input int n, input logic [31:0] first);
        for (int i = 0; i < n; i++) begin
            int waited = 0;
            step();
            bus.s_tvalid = 1'b1;
            bus.s_tdata  = first + 32'(i);
            while (!bus.s_tready && waited < 1000) begin
                step();
                waited++;
            end
            if (waited >= 1000) begin
                check("push_tready", 32'(bus.s_tready), 32'd1);
                break;
            end
        end
        step();
        bus.s_tvalid = 1'b0;
    endtask

    task automatic wait_b(input int n);
        int cyc = 0;
        while (b_n < n && cyc < 2000) begin
            step();
            cyc++;
        end
        step();
        check("b_count", 32'(b_n), 32'(n));
    endtask

    task automatic check_bursts(input int nb, input logic [31:0] first);
        check("beats", 32'(w_q.size()), 32'(nb * 16));
        for (int k = 0; k < nb; k++) begin
            logic [31:0] mask = '0;
            for (int i = 0; i < 16; i++) begin
                if ((k * 16 + i) < w_q.size() && wl_q[k * 16 + i]) mask[i] = 1'b1;
            end
            check("wlast_mask", mask, 32'h0000_8000);
        end
        for (int i = 0; i < nb * 16; i++) begin
            if (i < w_q.size()) check("wdata", w_q[i], first + 32'(i));
        end
        check("aw_fields", 32'(aw_field_err), 32'd0);
        check("wstrb", 32'(wstrb_err), 32'd0);
        check("w_before_aw", 32'(w_order_err), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        enable = 1'b0;
        bus.s_tvalid = 1'b0;
        bus.s_tdata = '0;
        bus.awready = 1'b1;
        bus.wready = 1'b1;
        bus.bresp = 2'b00;
        bus.bid = 4'h0;
        repeat (3) step();
        reset = 1'b0;
        step();

        // Reset state
        check("rst_awvalid", 32'(bus.awvalid), 32'd0);
        check("rst_wvalid", 32'(bus.wvalid), 32'd0);
        check("rst_bready", 32'(bus.bready), 32'd0);
        check("rst_wr_ptr", wr_ptr, 32'd0);
        check("rst_wrap", 32'(wrap), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_awaddr", bus.awaddr, BASE);
        check("rst_awlen", 32'(bus.awlen), 32'd15);
        check("rst_awburst", 32'(bus.awburst), 32'd1);
        check("rst_awid", 32'(bus.awid), 32'd5);
        check("rst_wstrb", 32'(bus.wstrb), 32'hF);

        // Single burst of 0..15
        enable = 1'b1;
        push_words(16, 32'd0);
        wait_b(1);
        check("t1_aw_n", 32'(aw_q.size()), 32'd1);
        check("t1_awaddr", aw_q[0], BASE);
        check_bursts(1, 32'd0);
        check("t1_wr_ptr", wr_ptr, 32'd64);
        check("t1_err", 32'(err), 32'd0);
        check("t1_busy", 32'(busy), 32'd0);
        check("t1_wrap_n", 32'(wrap_n), 32'd0);

        // Threshold: 15 words idle, 16th word starts AW two cycles later
        do_reset();
        enable = 1'b1;
        push_words(15, 32'd100);
        repeat (5) step();
        check("t2_awv_15", 32'(awv_n), 32'd0);
        check("t2_busy_15", 32'(busy), 32'd0);
        step();
        bus.s_tvalid = 1'b1;
        bus.s_tdata = 32'd115;
        check("t2_tready", 32'(bus.s_tready), 32'd1);
        step();
        bus.s_tvalid = 1'b0;
        check("t2_awv_cyc1", 32'(bus.awvalid), 32'd0);
        step();
        check("t2_awv_cyc2", 32'(bus.awvalid), 32'd1);
        check("t2_awaddr", bus.awaddr, BASE);
        check("t2_busy", 32'(busy), 32'd1);
        wait_b(1);
        check_bursts(1, 32'd100);

        // Wrap of a 128-byte ring
        do_reset();
        enable = 1'b1;
        push_words(48, 32'd200);
        wait_b(3);
        check("t3_aw_n", 32'(aw_q.size()), 32'd3);
        check("t3_aw0", aw_q[0], BASE);
        check("t3_aw1", aw_q[1], BASE + 32'd64);
        check("t3_aw2", aw_q[2], BASE);
        check("t3_wrap_n", 32'(wrap_n), 32'd1);
        check("t3_wrap_at_b", 32'(wrap_at_b), 32'd2);
        check("t3_wr_ptr", wr_ptr, 32'd64);
        check_bursts(3, 32'd200);

        // W backpressure fills the FIFO; nothing lost or reordered
        do_reset();
        enable = 1'b1;
        bus.wready = 1'b0;
        push_words(32, 32'd300);
        check("t4_full_tready", 32'(bus.s_tready), 32'd0);
        check("t4_busy", 32'(busy), 32'd1);
        repeat (5) step();
        check("t4_hold_tready", 32'(bus.s_tready), 32'd0);
        check("t4_no_beats", 32'(w_q.size()), 32'd0);
        check("t4_aw_n1", 32'(aw_q.size()), 32'd1);
        bus.wready = 1'b1;
        push_words(8, 32'd332);
        wait_b(2);
        repeat (5) step();
        check("t4_aw_n2", 32'(aw_q.size()), 32'd2);
        check("t4_idle", 32'(busy), 32'd0);
        push_words(8, 32'd340);
        wait_b(3);
        check_bursts(3, 32'd300);

        // Sticky error; pointer still advances
        do_reset();
        enable = 1'b1;
        bus.bresp = 2'b10;
        push_words(16, 32'd500);
        wait_b(1);
        check("t5_err1", 32'(err), 32'd1);
        check("t5_ptr1", wr_ptr, 32'd64);
        bus.bresp = 2'b00;
        push_words(32, 32'd516);
        wait_b(3);
        check("t5_err3", 32'(err), 32'd1);
        check("t5_ptr3", wr_ptr, 32'd64);
        check_bursts(3, 32'd500);

        // enable dropped mid-burst
        do_reset();
        enable = 1'b1;
        fork
            push_words(32, 32'd400);
            begin
                int g = 0;
                while (w_q.size() < 5 && g < 500) begin
                    step();
                    g++;
                end
                enable = 1'b0;
            end
        join
        wait_b(1);
        repeat (20) step();
        check("t6_aw_n1", 32'(aw_q.size()), 32'd1);
        check("t6_beats1", 32'(w_q.size()), 32'd16);
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_awv_off", 32'(bus.awvalid), 32'd0);
        enable = 1'b1;
        wait_b(2);
        check("t6_aw_n2", 32'(aw_q.size()), 32'd2);
        check("t6_aw1", aw_q[1], BASE + 32'd64);
        check_bursts(2, 32'd400);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
